// File: rtl/lector_instruccion_pkg.sv
// lector_pkg: shared types and constants for the instruction fetch reader.
// Revision: 1.0
`default_nettype none

package lector_pkg;

  typedef enum logic [0:0] {
    LEER    = 1'b0,
    ENTREGA = 1'b1
  } estado_t;

  localparam int INC_PC      = 4;
  localparam int BYTES_INSTR = 4;
  localparam int ANCHO_BYTE  = 8;
  localparam int ANCHO_CNT   = $clog2(BYTES_INSTR);

  // Big-endian lanes: the byte read from pc lands in lane 0 (bits 31:24).
  localparam int LANE0_LSB = 24;
  localparam int LANE1_LSB = 16;
  localparam int LANE2_LSB = 8;
  localparam int LANE3_LSB = 0;

  function automatic logic ultimo_byte(input logic [ANCHO_CNT-1:0] cnt);
    return cnt == ANCHO_CNT'(BYTES_INSTR - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lector_instruccion_if.sv
// lector_instruccion_if: memory-side and decoder-side bus of the fetch reader.
// Revision: 1.0
`default_nettype none

interface lector_instruccion_if #(
  parameter int ANCHO_DIR = 32
) ();

  logic                 mem_rd;
  logic [ANCHO_DIR-1:0] mem_dir;
  logic                 mem_ack;
  logic [7:0]           mem_dato;
  logic                 instr_valid;
  logic                 instr_ready;
  logic [31:0]          instr;
  logic [ANCHO_DIR-1:0] pc_instr;
  logic                 salto_en;
  logic [ANCHO_DIR-1:0] salto_dir;
  logic                 error_alin;

  modport master (
    output mem_rd, mem_dir, instr_valid, instr, pc_instr, error_alin,
    input  mem_ack, mem_dato, instr_ready, salto_en, salto_dir
  );

  modport slave (
    input  mem_rd, mem_dir, instr_valid, instr, pc_instr, error_alin,
    output mem_ack, mem_dato, instr_ready, salto_en, salto_dir
  );

endinterface

`default_nettype wire

// File: rtl/lector_instruccion_ensamblador.sv
// ensamblador_bytes: 4-byte shift register building the big-endian instruction word.
// Revision: 1.0
`default_nettype none

module ensamblador_bytes
  import lector_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        i_captura,
  input  wire logic        i_limpiar,
  input  wire logic [7:0]  i_byte,
  output logic      [31:0] o_palabra
);

  logic [31:0] r_palabra;

  // After four shifts the first captured byte sits in lane 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_palabra <= '0;
    end else if (i_limpiar) begin
      r_palabra <= '0;
    end else if (i_captura) begin
      r_palabra[LANE0_LSB +: ANCHO_BYTE] <= r_palabra[LANE1_LSB +: ANCHO_BYTE];
      r_palabra[LANE1_LSB +: ANCHO_BYTE] <= r_palabra[LANE2_LSB +: ANCHO_BYTE];
      r_palabra[LANE2_LSB +: ANCHO_BYTE] <= r_palabra[LANE3_LSB +: ANCHO_BYTE];
      r_palabra[LANE3_LSB +: ANCHO_BYTE] <= i_byte;
    end
  end

  assign o_palabra = r_palabra;

endmodule

`default_nettype wire

// File: rtl/lector_instruccion.sv
// lector_instruccion: byte-wise instruction fetch with valid/ready delivery and branch redirect.
// Optional macro LECTOR_ALIN_CHK_EN: flag misaligned branch targets and force them word-aligned.
`default_nettype none

module lector_instruccion
  import lector_pkg::*;
#(
  parameter int                   ANCHO_DIR  = 32,
  parameter logic [ANCHO_DIR-1:0] PC_INICIAL = '0
) (
  input wire logic              clk,
  input wire logic              rst_n,
  lector_instruccion_if.master  bus
);

  estado_t                r_estado;
  estado_t                w_estado_sig;
  logic [ANCHO_DIR-1:0]   r_pc;
  logic [ANCHO_DIR-1:0]   w_pc_sig;
  logic [ANCHO_CNT-1:0]   r_cnt;
  logic [ANCHO_CNT-1:0]   w_cnt_sig;
  logic                   w_limpiar;
  logic                   w_mem_rd;
  logic                   w_captura;
  logic [ANCHO_DIR-1:0]   w_destino;
  logic [31:0]            w_palabra;

  // Gating with rst_n keeps the request low while reset is held even though the state is LEER.
  assign w_mem_rd  = (r_estado == LEER) && rst_n;
  assign w_captura = w_mem_rd && bus.mem_ack;

`ifdef LECTOR_ALIN_CHK_EN
  logic r_error_alin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_error_alin <= 1'b0;
    end else if (bus.salto_en && (bus.salto_dir[1:0] != 2'b00)) begin
      r_error_alin <= 1'b1;
    end
  end

  assign w_destino      = {bus.salto_dir[ANCHO_DIR-1:2], 2'b00};
  assign bus.error_alin = r_error_alin;
`else
  assign w_destino      = bus.salto_dir;
  assign bus.error_alin = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= LEER;
      r_pc     <= PC_INICIAL;
      r_cnt    <= '0;
    end else begin
      r_estado <= w_estado_sig;
      r_pc     <= w_pc_sig;
      r_cnt    <= w_cnt_sig;
    end
  end

  // A branch wins over everything; a word handed over in the same cycle is still consumed.
  always_comb begin
    w_estado_sig = r_estado;
    w_pc_sig     = r_pc;
    w_cnt_sig    = r_cnt;
    w_limpiar    = 1'b0;
    if (bus.salto_en) begin
      w_estado_sig = LEER;
      w_pc_sig     = w_destino;
      w_cnt_sig    = '0;
      w_limpiar    = 1'b1;
    end else begin
      case (r_estado)
        LEER: begin
          if (w_captura) begin
            if (ultimo_byte(r_cnt)) begin
              w_cnt_sig    = '0;
              w_estado_sig = ENTREGA;
            end else begin
              w_cnt_sig = r_cnt + 1'b1;
            end
          end
        end
        ENTREGA: begin
          if (bus.instr_ready) begin
            w_pc_sig     = r_pc + ANCHO_DIR'(INC_PC);
            w_estado_sig = LEER;
          end
        end
        default: w_estado_sig = LEER;
      endcase
    end
  end

  ensamblador_bytes u_ensamblador (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_captura (w_captura && !bus.salto_en),
    .i_limpiar (w_limpiar),
    .i_byte    (bus.mem_dato),
    .o_palabra (w_palabra)
  );

  assign bus.mem_rd      = w_mem_rd;
  assign bus.mem_dir     = w_mem_rd ? (r_pc + ANCHO_DIR'(r_cnt)) : '0;
  assign bus.instr_valid = (r_estado == ENTREGA);
  assign bus.instr       = (r_estado == ENTREGA) ? w_palabra : '0;
  assign bus.pc_instr    = (r_estado == ENTREGA) ? r_pc : '0;

endmodule

`default_nettype wire
